datapath_controller: RTL and testbench
======================================

DATAPATH_CONTROLLER -- requirements
Module: datapath_controller

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release synchronous to clock.
REQ-004 instr_valid  input  1  upstream presents an instruction word.
REQ-005 instr  input  32  RISC-V R-type instruction word.
REQ-006 instr_ready  output  1  controller can accept an instruction.
REQ-007 zero_flag  input  1  datapath ALU zero result.
REQ-008 read_reg_num1  output  5  datapath read port 1 select (rs1).
REQ-009 read_reg_num2  output  5  datapath read port 2 select (rs2).
REQ-010 write_reg  output  5  datapath write select (rd).
REQ-011 alu_control  output  4  datapath ALU operation.
REQ-012 regwrite  output  1  datapath register-file write enable.
REQ-013 done  output  1  one-cycle pulse: instruction retired.
REQ-014 illegal  output  1  one-cycle pulse: instruction rejected.
REQ-015 zero_out  output  1  zero_flag captured for the last retired instruction.
REQ-016 retired_cnt  output  CNT_W  count of retired instructions.

Function
REQ-017 FSM states IDLE, DECODE, EXECUTE, WRITEBACK; instr_ready=1 only in IDLE.
REQ-018 Accept occurs on rising edge with IDLE and instr_valid=1; instr latched internally; next state DECODE.
REQ-019 IDLE with instr_valid=0: remain IDLE, all outputs hold except done/illegal/regwrite = 0.
REQ-020 DECODE: drive read_reg_num1=instr[19:15], read_reg_num2=instr[24:20], write_reg=instr[11:7], alu_control per REQ-021; regwrite=0.
REQ-021 Legal decode only when opcode instr[6:0]=0110011; {funct7,funct3} map: 0000000/000 ADD->0010, 0100000/000 SUB->0110, 0000000/111 AND->0000, 0000000/110 OR->0001, 0000000/100 XOR->0011, 0000000/001 SLL->0100, 0000000/101 SRL->0101, 0100000/101 SRA->1000, 0000000/010 SLT->0111, 0000000/011 SLTU->1001.
REQ-022 Any other opcode/funct combination: DECODE -> IDLE, illegal=1 for that one cycle, no regwrite, retired_cnt and zero_out unchanged.
REQ-023 Legal: DECODE -> EXECUTE; register selects and alu_control held stable through EXECUTE and WRITEBACK.
REQ-024 EXECUTE: zero_flag sampled at its end into zero_out; EXECUTE -> WRITEBACK.
REQ-025 WRITEBACK: regwrite=1 for exactly this cycle unless rd=0 (regwrite stays 0); done=1 this cycle; retired_cnt increments; next state IDLE.
REQ-026 Latency: accept edge to done high = 3 cycles; next accept earliest the cycle after WRITEBACK (throughput one per 4 cycles).
REQ-027 retired_cnt saturates at all-ones; rd=0 instructions still count.
REQ-028 instr_valid/instr changes outside IDLE are ignored; no queuing.
REQ-029 regwrite, done, illegal never high simultaneously with instr_ready.

Reset
REQ-030 reset=0 asynchronously: state IDLE, instr_ready=1, regwrite=0, done=0, illegal=0, zero_out=0, retired_cnt=0, read_reg_num1/2=0, write_reg=0, alu_control=0010.
REQ-031 Reset mid-instruction (any state) aborts it: no regwrite, no done, counter not incremented; first accept possible on first rising edge with reset high.

Verification
REQ-032 Reset low then high, instr_valid=0 -> all outputs at REQ-030 values, instr_ready=1 held.
REQ-033 ADD x3,x1,x2 (0x002081B3) accepted -> DECODE sel 1/2, alu_control=0010; WRITEBACK 3 cycles later with write_reg=3, regwrite=1, done=1; retired_cnt=1.
REQ-034 SUB x5,x4,x4 (0x404202B3) -> alu_control=0110, zero_flag=1 in EXECUTE -> zero_out=1 after WRITEBACK; ADD x0,x1,x2 (0x00208033) -> done=1, regwrite=0, retired_cnt incremented.
REQ-035 Opcode 0010011 word, then funct7=0000001 R-type -> illegal pulse one cycle each after accept, regwrite never high, retired_cnt unchanged, back to IDLE.
REQ-036 instr_valid held high with back-to-back words -> accepts exactly every 4 cycles, words presented while busy ignored; reset low during EXECUTE -> regwrite/done never asserted, retired_cnt=0.
REQ-037 CNT_W=2, retire 5 instructions -> retired_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/datapath_controller.sv
// Multi-cycle controller for RISC-V R-type instructions: accepts one word,
// decodes it, steps through execute/writeback and drives the datapath selects.
module datapath_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             zero_flag,
  output logic [4:0]       read_reg_num1,
  output logic [4:0]       read_reg_num2,
  output logic [4:0]       write_reg,
  output logic [3:0]       alu_control,
  output logic             regwrite,
  output logic             done,
  output logic             illegal,
  output logic             zero_out,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_legal;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic [3:0]       r_alu;
  logic             r_zero;
  logic [CNT_W-1:0] r_cnt;
  logic             w_legal;
  logic [3:0]       w_alu;
  logic             w_accept;

  assign w_accept = (r_state == IDLE) && instr_valid;

  // Decode the word on the input bus so the selects are valid during DECODE.
  always_comb begin
    w_legal = 1'b0;
    w_alu   = 4'b0010;
    if (instr[6:0] == 7'b0110011) begin
      w_legal = 1'b1;
      case ({instr[31:25], instr[14:12]})
        10'b0000000_000: w_alu = 4'b0010;
        10'b0100000_000: w_alu = 4'b0110;
        10'b0000000_111: w_alu = 4'b0000;
        10'b0000000_110: w_alu = 4'b0001;
        10'b0000000_100: w_alu = 4'b0011;
        10'b0000000_001: w_alu = 4'b0100;
        10'b0000000_101: w_alu = 4'b0101;
        10'b0100000_101: w_alu = 4'b1000;
        10'b0000000_010: w_alu = 4'b0111;
        10'b0000000_011: w_alu = 4'b1001;
        default:         w_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (instr_valid) w_next = DECODE;
      DECODE:    w_next = r_legal ? EXECUTE : IDLE;
      EXECUTE:   w_next = WRITEBACK;
      WRITEBACK: w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Rejected words leave the ALU operation, zero capture and counter untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_legal <= 1'b0;
      r_rs1   <= 5'd0;
      r_rs2   <= 5'd0;
      r_rd    <= 5'd0;
      r_alu   <= 4'b0010;
      r_zero  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_legal <= w_legal;
        r_rs1   <= instr[19:15];
        r_rs2   <= instr[24:20];
        r_rd    <= instr[11:7];
        if (w_legal) r_alu <= w_alu;
      end
      if (r_state == EXECUTE) r_zero <= zero_flag;
      if ((r_state == WRITEBACK) && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign instr_ready   = (r_state == IDLE);
  assign done          = (r_state == WRITEBACK);
  assign regwrite      = (r_state == WRITEBACK) && (r_rd != 5'd0);
  assign illegal       = (r_state == DECODE) && !r_legal;
  assign read_reg_num1 = r_rs1;
  assign read_reg_num2 = r_rs2;
  assign write_reg     = r_rd;
  assign alu_control   = r_alu;
  assign zero_out      = r_zero;
  assign retired_cnt   = r_cnt;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed self-checking bench for datapath_controller; a second instance with
// a 2-bit counter shares the stimulus to exercise counter saturation.
module tb_datapath_controller;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        zero_flag;

  logic        instr_ready, regwrite, done, illegal, zero_out;
  logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
  logic [3:0]  alu_control;
  logic [15:0] retired_cnt;

  logic        sReady, sRegwrite, sDone, sIllegal, sZeroOut;
  logic [4:0]  sRs1, sRs2, sRd;
  logic [3:0]  sAlu;
  logic [1:0]  sCnt;

  int checks = 0;
  int passes = 0;

  datapath_controller dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .zero_flag(zero_flag),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
    .done(done), .illegal(illegal), .zero_out(zero_out),
    .retired_cnt(retired_cnt)
  );

  datapath_controller #(.CNT_W(2)) dutSmall (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(sReady), .zero_flag(zero_flag),
    .read_reg_num1(sRs1), .read_reg_num2(sRs2),
    .write_reg(sRd), .alu_control(sAlu), .regwrite(sRegwrite),
    .done(sDone), .illegal(sIllegal), .zero_out(sZeroOut),
    .retired_cnt(sCnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic valid, input logic [31:0] word,
                               input logic zf);
    instr_valid = valid;
    instr       = word;
    zero_flag   = zf;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic checkIdleResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(instr_ready), 32'd1);
    checkOutput({tag, "_regwrite"}, 32'(regwrite), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_illegal"}, 32'(illegal), 32'd0);
    checkOutput({tag, "_zero_out"}, 32'(zero_out), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(retired_cnt), 32'd0);
    checkOutput({tag, "_rs1"}, 32'(read_reg_num1), 32'd0);
    checkOutput({tag, "_rs2"}, 32'(read_reg_num2), 32'd0);
    checkOutput({tag, "_rd"}, 32'(write_reg), 32'd0);
    checkOutput({tag, "_alu"}, 32'(alu_control), 32'h2);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    checkIdleResetValues("rst_low");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkIdleResetValues("rst_rel");

    // ADD x3,x1,x2
    applyStimulus(1'b1, 32'h002081B3, 1'b0);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("add_dec_rs1", 32'(read_reg_num1), 32'd1);
    checkOutput("add_dec_rs2", 32'(read_reg_num2), 32'd2);
    checkOutput("add_dec_alu", 32'(alu_control), 32'h2);
    checkOutput("add_dec_ready", 32'(instr_ready), 32'd0);
    checkOutput("add_dec_regwrite", 32'(regwrite), 32'd0);
    checkOutput("add_dec_illegal", 32'(illegal), 32'd0);
    @(negedge clock);
    checkOutput("add_ex_done", 32'(done), 32'd0);
    @(negedge clock);
    checkOutput("add_wb_rd", 32'(write_reg), 32'd3);
    checkOutput("add_wb_regwrite", 32'(regwrite), 32'd1);
    checkOutput("add_wb_done", 32'(done), 32'd1);
    checkOutput("add_wb_ready", 32'(instr_ready), 32'd0);
    @(negedge clock);
    checkOutput("add_cnt", 32'(retired_cnt), 32'd1);
    checkOutput("add_cnt_small", 32'(sCnt), 32'd1);
    checkOutput("add_idle_done", 32'(done), 32'd0);
    checkOutput("add_idle_regwrite", 32'(regwrite), 32'd0);
    checkOutput("add_idle_ready", 32'(instr_ready), 32'd1);
    checkOutput("add_idle_rd_hold", 32'(write_reg), 32'd3);

    // SUB x5,x4,x4 with zero result
    applyStimulus(1'b1, 32'h404202B3, 1'b0);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("sub_dec_alu", 32'(alu_control), 32'h6);
    checkOutput("sub_dec_rs1", 32'(read_reg_num1), 32'd4);
    @(negedge clock);
    zero_flag = 1'b1;
    @(negedge clock);
    zero_flag = 1'b0;
    checkOutput("sub_wb_rd", 32'(write_reg), 32'd5);
    checkOutput("sub_wb_regwrite", 32'(regwrite), 32'd1);
    @(negedge clock);
    checkOutput("sub_zero_out", 32'(zero_out), 32'd1);
    checkOutput("sub_cnt", 32'(retired_cnt), 32'd2);
    checkOutput("sub_cnt_small", 32'(sCnt), 32'd2);

    // ADD x0,x1,x2: retires without a register write
    applyStimulus(1'b1, 32'h00208033, 1'b0);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("addx0_wb_done", 32'(done), 32'd1);
    checkOutput("addx0_wb_regwrite", 32'(regwrite), 32'd0);
    @(negedge clock);
    checkOutput("addx0_cnt", 32'(retired_cnt), 32'd3);
    checkOutput("addx0_cnt_small", 32'(sCnt), 32'd3);
    checkOutput("addx0_zero_out", 32'(zero_out), 32'd0);

    // Non-R-type opcode (addi x1,x0,5)
    applyStimulus(1'b1, 32'h00500093, 1'b0);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("opimm_illegal", 32'(illegal), 32'd1);
    checkOutput("opimm_regwrite", 32'(regwrite), 32'd0);
    checkOutput("opimm_done", 32'(done), 32'd0);
    @(negedge clock);
    checkOutput("opimm_illegal_end", 32'(illegal), 32'd0);
    checkOutput("opimm_ready", 32'(instr_ready), 32'd1);
    checkOutput("opimm_cnt", 32'(retired_cnt), 32'd3);

    // funct7=0000001 (MUL x3,x1,x2) is rejected
    applyStimulus(1'b1, 32'h022081B3, 1'b1);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mul_illegal", 32'(illegal), 32'd1);
    checkOutput("mul_regwrite", 32'(regwrite), 32'd0);
    @(negedge clock);
    zero_flag = 1'b0;
    checkOutput("mul_illegal_end", 32'(illegal), 32'd0);
    checkOutput("mul_ready", 32'(instr_ready), 32'd1);
    checkOutput("mul_cnt", 32'(retired_cnt), 32'd3);
    checkOutput("mul_zero_hold", 32'(zero_out), 32'd0);
    checkOutput("mul_alu_hold", 32'(alu_control), 32'h2);

    // AND x6,x7,x8: fourth retirement saturates the 2-bit counter
    applyStimulus(1'b1, 32'h0083F333, 1'b0);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("and_dec_alu", 32'(alu_control), 32'h0);
    repeat (3) @(negedge clock);
    checkOutput("and_cnt", 32'(retired_cnt), 32'd4);
    checkOutput("and_cnt_small", 32'(sCnt), 32'd3);

    // Back-to-back: SLT x9,x10,x11 then SRA x12,x13,x14 with valid held high
    applyStimulus(1'b1, 32'h00B524B3, 1'b0);
    @(negedge clock);
    instr = 32'h0083C333;
    checkOutput("b2b_dec_alu", 32'(alu_control), 32'h7);
    checkOutput("b2b_dec_rs1", 32'(read_reg_num1), 32'd10);
    @(negedge clock);
    instr = 32'h40E6D633;
    checkOutput("b2b_ex_ready", 32'(instr_ready), 32'd0);
    checkOutput("b2b_ex_rs1_hold", 32'(read_reg_num1), 32'd10);
    checkOutput("b2b_ex_alu_hold", 32'(alu_control), 32'h7);
    @(negedge clock);
    checkOutput("b2b_wb_done", 32'(done), 32'd1);
    checkOutput("b2b_wb_rd", 32'(write_reg), 32'd9);
    @(negedge clock);
    checkOutput("b2b_idle_ready", 32'(instr_ready), 32'd1);
    checkOutput("b2b_cnt", 32'(retired_cnt), 32'd5);
    checkOutput("b2b_cnt_small", 32'(sCnt), 32'd3);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("sra_dec_alu", 32'(alu_control), 32'h8);
    checkOutput("sra_dec_rs1", 32'(read_reg_num1), 32'd13);
    checkOutput("sra_dec_rs2", 32'(read_reg_num2), 32'd14);
    checkOutput("sra_dec_rd", 32'(write_reg), 32'd12);
    @(negedge clock);

    // Reset asserted in EXECUTE aborts the instruction
    reset = 1'b0;
    #1;
    checkIdleResetValues("abort");
    @(posedge clock);
    #1;
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_regwrite", 32'(regwrite), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b1, 32'h0083B333, 1'b0);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("post_rst_accept", 32'(instr_ready), 32'd0);
    checkOutput("post_rst_alu", 32'(alu_control), 32'h9);
    checkOutput("post_rst_cnt", 32'(retired_cnt), 32'd0);
    repeat (3) @(negedge clock);
    checkOutput("post_rst_cnt_end", 32'(retired_cnt), 32'd1);
    checkOutput("post_rst_cnt_small", 32'(sCnt), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
